mac_accumulator: RTL and testbench
==================================

MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 Parameter PROD_W, default 8: signed product width delivered by the upstream Booth radix-4 multiplier.
REQ-002 Parameter ACC_W, default 16: signed accumulator and result width; ACC_W > PROD_W.
REQ-003 Parameter CNT_W, default 8: width of the product counter.
REQ-004 Port clk, input, 1: the single clock; all logic is on its rising edge.
REQ-005 Port rst, input, 1: reset, synchronous and active-high.
REQ-006 Port in_valid, input, 1: the product on in_data is valid.
REQ-007 Port in_ready, output, 1: the block can accept a product this cycle.
REQ-008 Port in_data, input, PROD_W: signed product from the multiplier.
REQ-009 Port in_first, input, 1: this product starts a new accumulation window.
REQ-010 Port in_last, input, 1: this product closes the window.
REQ-011 Port clear, input, 1: abandon the open window.
REQ-012 Port out_valid, output, 1: the result registers hold an unconsumed result.
REQ-013 Port out_ready, input, 1: the consumer accepts the result.
REQ-014 Port out_data, output, ACC_W: signed accumulated result.
REQ-015 Port out_count, output, CNT_W: number of products in the window.
REQ-016 Port out_sat, output, 1: saturation occurred at least once in the window.

Function
REQ-017 Acceptance: a product is accepted when in_valid && in_ready at a clock edge.
REQ-018 Ready rule: in_ready = !out_valid || out_ready, giving a one-deep output buffer with no bubble.
REQ-019 States: IDLE (no open window, acc = 0) and ACCUM (window open).
REQ-020 IDLE -> ACCUM on an accepted product without in_last.
REQ-021 ACCUM -> IDLE on an accepted product with in_last, or on clear.
REQ-022 Window start: an accepted product with in_first, or any accepted product in IDLE, sets acc = sign-extended in_data, count = 1 and sat = 0, discarding any open window.
REQ-023 Accumulate: any other accepted product sets acc = sat_add(acc, sign-extended in_data).
REQ-024 Count: count increments per accepted product and holds at 2^CNT_W-1 instead of wrapping.
REQ-025 Saturating add: the sum is formed in ACC_W+1 bits and clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
REQ-026 Saturation flag: any clamp sets the sticky window sat flag.
REQ-027 Window close: on an accepted product with in_last, the final acc/count/sat (including that product) load into out_data/out_count/out_sat and out_valid = 1 at the next edge (latency 1 cycle).
REQ-028 Window reset on close: in the same edge, acc = 0, count = 0, sat = 0 and state = IDLE.
REQ-029 Single-product window: in_first && in_last together yields out_data = that product, out_count = 1.
REQ-030 Output hold: out_valid and out_* stay stable until out_valid && out_ready.
REQ-031 Output release: on out_valid && out_ready with no new close in that cycle, out_valid = 0 next edge.
REQ-032 Simultaneous consume and close: when out_ready consumes the old result and a new close occurs in the same cycle, the new result loads and out_valid stays 1.
REQ-033 Clear: clear sets acc = 0, count = 0, sat = 0 and state = IDLE, and does not touch the output registers.
REQ-034 Clear with acceptance: if clear coincides with an accepted product, the product is treated as a window start (REQ-022), and in_last still closes the window.
REQ-035 Idle inputs: in_first, in_last and in_data are ignored when no product is accepted.

Reset
REQ-036 rst forces state = IDLE; acc, count, sat = 0; out_valid = 0; out_data = 0; out_count = 0; out_sat = 0; in_ready = 1 in the following cycle.
REQ-037 rst has priority over every other input, and a window open at reset is discarded without producing output.

Structure
REQ-038 Package mac_pkg holds PROD_W/ACC_W/CNT_W defaults, the state enum (IDLE, ACCUM) and the ACC_MAX/ACC_MIN constants.
REQ-039 The saturating adder is a separate combinational sub-module, mac_sat_add, which outputs the sum and a clamp flag.
REQ-040 mac_accumulator contains only control and the registers.

Verification
REQ-041 Basic window: products 10, -3, 7, 20 with first on 1st and last on 4th, out_ready = 1 -> one cycle later out_data = 34, out_count = 4, out_sat = 0, out_valid for one cycle.
REQ-042 Positive saturation: 300 products of +127, first..last -> out_data = 32767, out_sat = 1, out_count = 255.
REQ-043 Negative saturation: 300 products of -128 -> out_data = -32768, out_sat = 1.
REQ-044 Backpressure: out_ready = 0 after a close -> in_ready = 0 and out_* stable; a second window's last stays pending; raise out_ready -> first result consumed, second loads the next edge, with no loss or duplication.
REQ-045 Single-product window: in_first = in_last = 1, in_data = -128 -> out_data = -128, out_count = 1.
REQ-046 Clear and reset mid-window: 5, 6 then clear, then 9 with last -> out_data = 9, count = 1; rst asserted after 2 products of an open window -> no output, all outputs 0, next window starts from 0.

Source files
------------

// File: rtl/mac_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_pkg : shared defaults, window state type and accumulator limits       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
package mac_pkg;

    localparam int DEF_PROD_W = 8;
    localparam int DEF_ACC_W  = 16;
    localparam int DEF_CNT_W  = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACCUM = 1'b1
    } state_t;

    localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

endpackage
`default_nettype wire

// File: rtl/mac_accumulator_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_accumulator_if : product input stream and result output stream       |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
interface mac_accumulator_if
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [PROD_W-1:0] in_data;
    logic                     in_first;
    logic                     in_last;
    logic                     clear;
    logic                     out_valid;
    logic                     out_ready;
    logic signed [ACC_W-1:0]  out_data;
    logic [CNT_W-1:0]         out_count;
    logic                     out_sat;

    modport master (
        output in_valid, in_data, in_first, in_last, clear, out_ready,
        input  in_ready, out_valid, out_data, out_count, out_sat
    );

    modport slave (
        input  in_valid, in_data, in_first, in_last, clear, out_ready,
        output in_ready, out_valid, out_data, out_count, out_sat
    );
endinterface
`default_nettype wire

// File: rtl/mac_sat_add.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_sat_add : signed add clamped to the ACC_W range, with clamp flag      |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mac_sat_add
    import mac_pkg::*;
#(
    parameter int ACC_W = DEF_ACC_W
) (
    input  wire logic signed [ACC_W-1:0] a,
    input  wire logic signed [ACC_W-1:0] b,
    output logic signed [ACC_W-1:0]      sum,
    output logic                         clamp
);
    localparam logic signed [ACC_W-1:0] c_acc_max = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] c_acc_min = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W:0] w_full;

    assign w_full = {a[ACC_W-1], a} + {b[ACC_W-1], b};

    // Overflow shows up as the two top bits of the widened sum disagreeing.
    always_comb begin
        clamp = w_full[ACC_W] ^ w_full[ACC_W-1];
        sum   = w_full[ACC_W-1:0];
        if (clamp) begin
            sum = w_full[ACC_W] ? c_acc_min : c_acc_max;
        end
    end
endmodule
`default_nettype wire

// File: rtl/mac_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | mac_accumulator : windowed saturating accumulator with one-deep output   |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module mac_accumulator
    import mac_pkg::*;
#(
    parameter int PROD_W = DEF_PROD_W,
    parameter int ACC_W  = DEF_ACC_W,
    parameter int CNT_W  = DEF_CNT_W
) (
    input  wire logic         clk,
    input  wire logic         rst,
    mac_accumulator_if.slave  bus
);
    state_t                  r_state;
    logic signed [ACC_W-1:0] r_acc;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sat;
    logic                    r_out_valid;
    logic signed [ACC_W-1:0] r_out_data;
    logic [CNT_W-1:0]        r_out_count;
    logic                    r_out_sat;

    logic                    w_in_ready;
    logic                    w_accept;
    logic                    w_start;
    logic signed [ACC_W-1:0] w_sext;
    logic signed [ACC_W-1:0] w_sum;
    logic                    w_clamp;
    logic signed [ACC_W-1:0] w_acc_next;
    logic [CNT_W-1:0]        w_cnt_next;
    logic                    w_sat_next;

    assign w_in_ready = !r_out_valid || bus.out_ready;
    assign w_accept   = bus.in_valid && w_in_ready;
    // A coincident clear makes the accepted product open a fresh window.
    assign w_start    = bus.in_first || (r_state == IDLE) || bus.clear;
    assign w_sext     = {{(ACC_W-PROD_W){bus.in_data[PROD_W-1]}}, bus.in_data};

    mac_sat_add #(.ACC_W(ACC_W)) u_sat_add (
        .a     (r_acc),
        .b     (w_sext),
        .sum   (w_sum),
        .clamp (w_clamp)
    );

    always_comb begin
        w_acc_next = w_sum;
        w_cnt_next = (&r_cnt) ? r_cnt : r_cnt + 1'b1;
        w_sat_next = r_sat | w_clamp;
        if (w_start) begin
            w_acc_next = w_sext;
            w_cnt_next = {{(CNT_W-1){1'b0}}, 1'b1};
            w_sat_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_count <= '0;
            r_out_sat   <= 1'b0;
        end else if (w_accept && bus.in_last) begin
            r_out_valid <= 1'b1;
            r_out_data  <= w_acc_next;
            r_out_count <= w_cnt_next;
            r_out_sat   <= w_sat_next;
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_sat       <= 1'b0;
        end else begin
            if (r_out_valid && bus.out_ready) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept) begin
                r_state <= ACCUM;
                r_acc   <= w_acc_next;
                r_cnt   <= w_cnt_next;
                r_sat   <= w_sat_next;
            end else if (bus.clear) begin
                r_state <= IDLE;
                r_acc   <= '0;
                r_cnt   <= '0;
                r_sat   <= 1'b0;
            end
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.out_data  = r_out_data;
    assign bus.out_count = r_out_count;
    assign bus.out_sat   = r_out_sat;
endmodule
`default_nettype wire

// File: tb/tb_mac_accumulator.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_mac_accumulator : directed and random stimulus against a window model |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_mac_accumulator;
    localparam int ACC_MAXI = 32767;
    localparam int ACC_MINI = -32768;
    localparam int CNT_MAXI = 255;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    mac_accumulator_if #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) bus ();

    mac_accumulator #(.PROD_W(8), .ACC_W(16), .CNT_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Reference: the open window is a plain integer sum plus product count.
    int m_acc = 0, m_cnt = 0;
    bit m_sat = 0, m_open = 0, m_init = 0;
    bit m_ov = 0, m_os = 0;
    int m_od = 0, m_oc = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic step(input bit v, input int d, input bit f, input bit l,
                        input bit c, input bit ordy, input bit r);
        bit acc_ok;
        int s;
        logic [7:0] d8;
        d8 = d[7:0];
        bus.in_valid  = v;
        bus.in_data   = d8;
        bus.in_first  = f;
        bus.in_last   = l;
        bus.clear     = c;
        bus.out_ready = ordy;
        rst           = r;
        #1;
        acc_ok = v && (!m_ov || ordy);
        if (m_init) chk("in_ready", longint'(bus.in_ready), longint'(!m_ov || ordy));
        @(posedge clk);
        if (r) begin
            m_acc = 0; m_cnt = 0; m_sat = 0; m_open = 0;
            m_ov = 0; m_od = 0; m_oc = 0; m_os = 0; m_init = 1;
        end else begin
            if (acc_ok) begin
                if (f || !m_open || c) begin
                    m_acc = d; m_cnt = 1; m_sat = 0;
                end else begin
                    s = m_acc + d;
                    if (s > ACC_MAXI) begin s = ACC_MAXI; m_sat = 1; end
                    if (s < ACC_MINI) begin s = ACC_MINI; m_sat = 1; end
                    m_acc = s;
                    m_cnt = (m_cnt < CNT_MAXI) ? m_cnt + 1 : CNT_MAXI;
                end
            end
            if (acc_ok && l) begin
                m_ov = 1; m_od = m_acc; m_oc = m_cnt; m_os = m_sat;
                m_acc = 0; m_cnt = 0; m_sat = 0; m_open = 0;
            end else begin
                if (m_ov && ordy) m_ov = 0;
                if (acc_ok) m_open = 1;
                else if (c) begin m_acc = 0; m_cnt = 0; m_sat = 0; m_open = 0; end
            end
        end
        @(negedge clk);
        if (m_init) begin
            chk("out_valid", longint'(bus.out_valid), longint'(m_ov));
            chk("out_data",  longint'($signed(bus.out_data)), longint'(m_od));
            chk("out_count", longint'(bus.out_count), longint'(m_oc));
            chk("out_sat",   longint'(bus.out_sat), longint'(m_os));
        end
    endtask

    task automatic idle(input bit ordy);
        step(0, 0, 0, 0, 0, ordy, 0);
    endtask

    initial begin
        bus.in_valid = 0; bus.in_data = '0; bus.in_first = 0; bus.in_last = 0;
        bus.clear = 0; bus.out_ready = 1;
        @(negedge clk);
        step(0, 0, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_data", bus.out_data, 0);

        // Basic window
        step(1, 10, 1, 0, 0, 1, 0);
        step(1, -3, 0, 0, 0, 1, 0);
        step(1, 7, 0, 0, 0, 1, 0);
        step(1, 20, 0, 1, 0, 1, 0);
        chk("basic_valid", bus.out_valid, 1);
        chk("basic_data", $signed(bus.out_data), 34);
        chk("basic_count", bus.out_count, 4);
        chk("basic_sat", bus.out_sat, 0);
        idle(1);
        chk("basic_release", bus.out_valid, 0);

        // Positive saturation with count pinned at its maximum
        for (int i = 0; i < 300; i++) step(1, 127, i == 0, i == 299, 0, 1, 0);
        chk("psat_data", $signed(bus.out_data), 32767);
        chk("psat_count", bus.out_count, 255);
        chk("psat_sat", bus.out_sat, 1);
        idle(1);

        for (int i = 0; i < 300; i++) step(1, -128, i == 0, i == 299, 0, 1, 0);
        chk("nsat_data", $signed(bus.out_data), -32768);
        chk("nsat_sat", bus.out_sat, 1);
        idle(1);

        // Backpressure: second close waits until the first result is taken
        step(1, 5, 1, 0, 0, 0, 0);
        step(1, 6, 0, 1, 0, 0, 0);
        chk("bp_first", $signed(bus.out_data), 11);
        for (int i = 0; i < 3; i++) begin
            step(1, 3, 1, 1, 0, 0, 0);
            chk("bp_ready_low", bus.in_ready, 0);
            chk("bp_hold", $signed(bus.out_data), 11);
        end
        step(1, 3, 1, 1, 0, 1, 0);
        chk("bp_second_valid", bus.out_valid, 1);
        chk("bp_second_data", $signed(bus.out_data), 3);
        idle(1);
        chk("bp_drained", bus.out_valid, 0);

        step(1, -128, 1, 1, 0, 1, 0);
        chk("single_data", $signed(bus.out_data), -128);
        chk("single_count", bus.out_count, 1);
        idle(1);

        // Clear mid-window
        step(1, 5, 1, 0, 0, 1, 0);
        step(1, 6, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 1, 1, 0);
        step(1, 9, 0, 1, 0, 1, 0);
        chk("clr_data", $signed(bus.out_data), 9);
        chk("clr_count", bus.out_count, 1);
        idle(1);

        // Reset mid-window discards the window
        step(1, 40, 1, 0, 0, 1, 0);
        step(1, 50, 0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0, 1, 1);
        chk("rstmid_valid", bus.out_valid, 0);
        chk("rstmid_data", bus.out_data, 0);
        step(1, 4, 0, 0, 0, 1, 0);
        step(1, 8, 0, 1, 0, 1, 0);
        chk("rstmid_next_data", $signed(bus.out_data), 12);
        chk("rstmid_next_count", bus.out_count, 2);
        idle(1);

        // Random traffic, extremes favoured to exercise clamping
        for (int i = 0; i < 3000; i++) begin
            int d;
            d = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 0) ? 127 : -128)
                                             : int'($urandom_range(0, 255)) - 128;
            step($urandom_range(0, 9) < 7, d, $urandom_range(0, 9) < 1,
                 $urandom_range(0, 19) < 1, $urandom_range(0, 49) < 1,
                 $urandom_range(0, 9) < 7, $urandom_range(0, 199) < 1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
